// File: rtl/out_port_fifo.sv
// ---------------------------------------------------------------------------
// out_port_fifo
//   Output-port buffer between a processor's OUT instruction and an external
//   valid/ready consumer. The processor writes words with wr_en/wr_data and
//   stalls on full. The consumer sees the head word on out_data/out_valid and
//   takes it with out_ready. A write that arrives while the buffer is full and
//   nothing drains on the same edge is dropped and latched in the sticky ovfl
//   flag until ovfl_clr is pulsed.
//
//   The write side has no bypass. A word written into an empty buffer appears
//   on out_data one edge later.
//
// Parameters
//   WIDTH     data word width in bits
//   DEPTH     number of buffer entries (power of two, 2 or greater)
//
// Ports
//   CLK       single clock, rising-edge active
//   reset     asynchronous, active-low reset
//   wr_en     processor write strobe
//   wr_data   processor word to emit
//   full      buffer holds DEPTH words
//   out_valid out_data holds a valid head word
//   out_data  head-of-buffer word
//   out_ready consumer accepts the head word this edge
//   count     words currently held, 0..DEPTH
//   ovfl      sticky dropped-write flag
//   ovfl_clr  synchronous clear of ovfl; a drop on the same edge wins
// ---------------------------------------------------------------------------
module out_port_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovfl,
  input  logic                     ovfl_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage and control state
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ovfl_q,   ovfl_d;

  logic push;
  logic pop;
  logic drop;

  // Status flags come straight from the registered count, so they are glitch
  // free and settle to 0 as soon as reset clears count.
  assign out_valid = (count_q != '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign ovfl      = ovfl_q;

  // The head entry is read directly. It only changes when rd_ptr_q moves on a
  // pop, or when the slot under rd_ptr_q is first written into an empty buffer.
  assign out_data  = mem_q[rd_ptr_q];

  // A pop needs a valid head, so a pop on an empty buffer cannot happen. A
  // write into a full buffer is still accepted when a pop frees a slot on the
  // same edge.
  assign pop  = out_valid & out_ready;
  assign push = wr_en & (~full | pop);
  assign drop = wr_en & full & ~pop;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovfl_d   = ovfl_q;

    // The pointer width matches log2(DEPTH), so each pointer wraps modulo DEPTH
    // without extra logic.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;  // idle, or a push and pop together
    endcase

    // The clear is applied first so that a drop on the same edge overrides it.
    if (ovfl_clr) ovfl_d = 1'b0;
    if (drop)     ovfl_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments. All flops then
  // sample their inputs from before the edge, whatever order the blocks run in.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovfl_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovfl_q   <= ovfl_d;
    end
  end

  // NOTE: the storage array has no reset. Its contents only matter once count
  // marks an entry as occupied, and leaving it unreset lets it map onto plain
  // RAM or flops without a reset.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: doc/out_port_fifo.md
OUT_PORT_FIFO -- requirements
Module: out_port_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, buffer entries; power of two, 2 or greater.
REQ-003 SHALL have port CLK  input  1  single clock, all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_en  input  1  processor write strobe for an OUT instruction.
REQ-006 SHALL have port wr_data  input  WIDTH  processor word to emit.
REQ-007 SHALL have port full  output  1  buffer holds DEPTH words; processor stalls on it.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid head word.
REQ-009 SHALL have port out_data  output  WIDTH  head-of-buffer word.
REQ-010 SHALL have port out_ready  input  1  external consumer accepts the word.
REQ-011 SHALL have port count  output  log2(DEPTH)+1  number of words held, 0..DEPTH.
REQ-012 SHALL have port ovfl  output  1  sticky flag for a dropped write.
REQ-013 SHALL have port ovfl_clr  input  1  synchronous clear of ovfl.

Function
REQ-014 SHALL implement a circular buffer with write pointer, read pointer and occupancy counter; pointers wrap modulo DEPTH.
REQ-015 SHALL define a push as a rising edge with wr_en=1 that the buffer accepts under REQ-019/REQ-020.
REQ-016 SHALL define a pop as a rising edge with out_valid=1 and out_ready=1.
REQ-017 SHALL drive out_valid = (count != 0) and full = (count == DEPTH), both decoded from registered count.
REQ-018 SHALL drive out_data from the entry at the read pointer, so it changes only at a pop or at the first push into an empty buffer.
REQ-019 SHALL give a write into an empty buffer a latency of one edge: out_valid=1 and out_data=wr_data in the cycle after the push edge; no same-cycle bypass.
REQ-020 SHALL apply a simultaneous push and pop with 0<count<DEPTH: both take effect and count is unchanged.
REQ-021 SHALL treat a write while full with a simultaneous pop as accepted: data is stored in the freed slot and count stays DEPTH.
REQ-022 SHALL drop a write while full without a pop: no state change, ovfl set to 1 at that edge.
REQ-023 SHALL have no effect for a pop while empty, because out_valid=0 makes it impossible.
REQ-024 SHALL keep ovfl at 1 until ovfl_clr=1 at an edge; if ovfl_clr and a new drop occur on the same edge, ovfl SHALL be 1, so set wins.
REQ-025 SHALL hold out_data stable while out_valid=1 and out_ready=0, meeting the valid/ready hold rule.
REQ-026 SHALL leave the contents of unoccupied entries unspecified; the bench SHALL NOT check them.

Reset
REQ-027 SHALL, on reset=0 at any time and regardless of CLK, clear both pointers, count, and ovfl to 0 immediately.
REQ-028 SHALL, during reset, hold out_valid=0, full=0, and count=0; the value of out_data is don't-care.
REQ-029 SHALL discard any partial transfer in progress when reset asserts in mid-operation; no push or pop completes on the edge where reset is low.
REQ-030 SHALL accept the first push at the first rising edge after reset deasserts; buffer RAM is not cleared.

Verification
REQ-031 Single word: wr_en=1, wr_data=16'h0906, out_ready=0 for one edge -> next cycle out_valid=1, out_data=16'h0906, count=1; raise out_ready -> after one edge out_valid=0, count=0.
REQ-032 Fill/full: four pushes 16'h0001..16'h0004 with out_ready=0 -> full=1, count=4, ovfl=0; then drain with out_ready=1 -> words 1,2,3,4 in order, one per edge, then out_valid=0.
REQ-033 Overflow: with full=1, push 16'hBEEF and out_ready=0 -> ovfl=1, count=4, and the drain order is unchanged; ovfl_clr=1 for one edge -> ovfl=0.
REQ-034 Full pass-through: with full=1, wr_en=1 (16'h0005) and out_ready=1 on the same edge -> ovfl=0, count=4, head becomes 16'h0002, and 16'h0005 drains last.
REQ-035 Wrap-around: 10 words pushed and popped with random out_ready against a scoreboard -> no loss or reorder, and count matches the model every cycle.
REQ-036 Async reset: with count=3, pull reset low between edges -> count=0, out_valid=0, full=0 and ovfl=0 before the next edge; after release, a push of 16'h00AA comes out first.
